gate_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer for the two-input gate bank (AND/OR/NOT-a/NAND/NOR/XOR/XNOR).

---
 rtl/gate_bist_ctrl_if.sv | 37 +++
 rtl/gate_bist_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_bist_ctrl_if.sv
// gate_bist_ctrl_if: host/gate-bank signal bundle for the gate BIST sequencer.
// Signals: start, abort (host requests); gate_res[6:0] (bank outputs, bit0=and);
//          tst_a, tst_b (bank stimulus); busy, done, pass, fail_mask[6:0] (status).
// slave = sequencer side, master = host + gate bank side.
// Optional: GATE_BIST_ERR_CNT_EN adds err_cnt[7:0] (saturating mismatch count).
interface gate_bist_ctrl_if;
  logic       start;
  logic       abort;
  logic [6:0] gate_res;
  logic       tst_a;
  logic       tst_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] fail_mask;
`ifdef GATE_BIST_ERR_CNT_EN
  logic [7:0] err_cnt;

  modport slave (
    input  start, abort, gate_res,
    output tst_a, tst_b, busy, done, pass, fail_mask, err_cnt
  );
  modport master (
    output start, abort, gate_res,
    input  tst_a, tst_b, busy, done, pass, fail_mask, err_cnt
  );
`else
  modport slave (
    input  start, abort, gate_res,
    output tst_a, tst_b, busy, done, pass, fail_mask
  );
  modport master (
    output start, abort, gate_res,
    input  tst_a, tst_b, busy, done, pass, fail_mask
  );
`endif
endinterface

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: BIST sequencer sweeping a/b of the 7-gate bank and flagging per-gate mismatches.
// Latency: start sampled at edge 0, done pulses after edge 4*PASSES*(SETTLE+1); all outputs registered.
// Backpressure: none; start is only accepted in IDLE (no queuing), abort returns to IDLE next edge.
// Ports: clk, rst_n (async active-low); bus (gate_bist_ctrl_if.slave):
//   start/abort in, gate_res[6:0] in {xnor,xor,nor,nand,not_a,or,and},
//   tst_a/tst_b out, busy/done/pass out, fail_mask[6:0] out (sticky, gate_res bit order).
// Optional: GATE_BIST_ERR_CNT_EN adds err_cnt[7:0], a saturating count of mismatching bits.
module gate_bist_ctrl #(
  parameter int unsigned PASSES = 1,  // full 4-vector sweeps per run, 1..255
  parameter int unsigned SETTLE = 1   // cycles each vector is held before sampling, 1..15
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_bist_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);
  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic       tst_a_q, tst_a_d;
  logic       tst_b_q, tst_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [6:0] fail_mask_q, fail_mask_d;

  logic [6:0] expected;
  logic [6:0] mismatch;

  // Truth table is derived from the registered stimulus, so the compare in
  // CHECK always refers to the vector the bank has been settling on.
  assign expected = {~(tst_a_q ^ tst_b_q), tst_a_q ^ tst_b_q, ~(tst_a_q | tst_b_q),
                     ~(tst_a_q & tst_b_q), ~tst_a_q, tst_a_q | tst_b_q, tst_a_q & tst_b_q};
  assign mismatch = bus.gate_res ^ expected;

`ifdef GATE_BIST_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [3:0] mis_cnt;
  logic [8:0] err_sum;

  assign mis_cnt = 4'($countones(mismatch));
  // One extra bit catches the carry so the counter can clamp at 255.
  assign err_sum = {1'b0, err_cnt_q} + {5'd0, mis_cnt};
`endif

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    pass_cnt_d   = pass_cnt_q;
    settle_cnt_d = settle_cnt_q;
    tst_a_d      = tst_a_q;
    tst_b_d      = tst_b_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_mask_d  = fail_mask_q;
`ifdef GATE_BIST_ERR_CNT_EN
    err_cnt_d    = err_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // abort has priority over a simultaneous start
        if (bus.start && !bus.abort) begin
          state_d      = ST_APPLY;
          vec_d        = 2'd0;
          pass_cnt_d   = 8'd0;
          settle_cnt_d = 4'd0;
          tst_a_d      = 1'b0;
          tst_b_d      = 1'b0;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          fail_mask_d  = 7'd0;
`ifdef GATE_BIST_ERR_CNT_EN
          err_cnt_d    = 8'd0;
`endif
        end
      end

      ST_APPLY: begin
        if (bus.abort) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          pass_d       = 1'b0;
          settle_cnt_d = 4'd0;
        end else if (settle_cnt_q == LAST_SETTLE) begin
          state_d      = ST_CHECK;
          settle_cnt_d = 4'd0;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end

      ST_CHECK: begin
        // The compare of this cycle is kept even when aborting, so an
        // aborted run still reports everything it has already sampled.
        fail_mask_d = fail_mask_q | mismatch;
`ifdef GATE_BIST_ERR_CNT_EN
        err_cnt_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
`endif
        if (bus.abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (vec_q != 2'd3) begin
          state_d = ST_APPLY;
          vec_d   = vec_q + 2'd1;
          tst_a_d = vec_d[1];
          tst_b_d = vec_d[0];
        end else if (pass_cnt_q != LAST_PASS) begin
          state_d    = ST_APPLY;
          vec_d      = 2'd0;
          pass_cnt_d = pass_cnt_q + 8'd1;
          tst_a_d    = 1'b0;
          tst_b_d    = 1'b0;
        end else begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = ((fail_mask_q | mismatch) == 7'd0);
        end
      end

      ST_DONE: begin
        // done/pass were registered on entry; this cycle only returns home
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= 2'd0;
      pass_cnt_q   <= 8'd0;
      settle_cnt_q <= 4'd0;
      tst_a_q      <= 1'b0;
      tst_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_mask_q  <= 7'd0;
`ifdef GATE_BIST_ERR_CNT_EN
      err_cnt_q    <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      pass_cnt_q   <= pass_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      tst_a_q      <= tst_a_d;
      tst_b_q      <= tst_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_mask_q  <= fail_mask_d;
`ifdef GATE_BIST_ERR_CNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign bus.tst_a     = tst_a_q;
  assign bus.tst_b     = tst_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_mask_q;
`ifdef GATE_BIST_ERR_CNT_EN
  assign bus.err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: three sequencer instances (PASSES/SETTLE = 1/1, 2/1, 1/3) share
// start/abort and a faultable gate-bank model; a run-timeline model is compared every cycle.
module tb_gate_bist_ctrl;
  localparam int NI = 3;
  localparam int PP [NI] = '{1, 2, 1};
  localparam int SS [NI] = '{1, 1, 3};

  logic       clk;
  logic       rst_n;
  logic       start_r;
  logic       abort_r;
  logic [6:0] f0_r;   // stuck-at-0 bits of the bank
  logic [6:0] f1_r;   // stuck-at-1 bits of the bank

  logic       ta_w   [NI];
  logic       tb_w   [NI];
  logic       busy_w [NI];
  logic       done_w [NI];
  logic       pass_w [NI];
  logic [6:0] mask_w [NI];
`ifdef GATE_BIST_ERR_CNT_EN
  logic [7:0] err_w  [NI];
`endif

  int checks   = 0;
  int failures = 0;

  // Fault-free bank outputs {xnor,xor,nor,nand,not_a,or,and}, written out per input pair.
  function automatic logic [6:0] ideal(input logic a, input logic b);
    logic [1:0] ab;
    ab = {a, b};
    case (ab)
      2'b00:   return 7'h5C;
      2'b01:   return 7'h2E;
      2'b10:   return 7'h2A;
      default: return 7'h43;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    gate_bist_ctrl_if bus_i ();
    assign bus_i.start    = start_r;
    assign bus_i.abort    = abort_r;
    assign bus_i.gate_res = (ideal(bus_i.tst_a, bus_i.tst_b) & ~f0_r) | f1_r;
    gate_bist_ctrl #(.PASSES(PP[g]), .SETTLE(SS[g])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_i)
    );
    assign ta_w[g]   = bus_i.tst_a;
    assign tb_w[g]   = bus_i.tst_b;
    assign busy_w[g] = bus_i.busy;
    assign done_w[g] = bus_i.done;
    assign pass_w[g] = bus_i.pass;
    assign mask_w[g] = bus_i.fail_mask;
`ifdef GATE_BIST_ERR_CNT_EN
    assign err_w[g]  = bus_i.err_cnt;
`endif
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model: run timeline ----------------
  // ph: 0 idle, 1 running, 2 done cycle. kk = cycles elapsed since the accepting edge.
  // Within a run each vector occupies SETTLE+1 cycles, the last of which is the sample.
  int         ph    [NI] = '{0, 0, 0};
  int         kk    [NI] = '{0, 0, 0};
  logic [1:0] mv    [NI] = '{2'd0, 2'd0, 2'd0};
  logic       mbusy [NI] = '{1'b0, 1'b0, 1'b0};
  logic       mdone [NI] = '{1'b0, 1'b0, 1'b0};
  logic       mpass [NI] = '{1'b0, 1'b0, 1'b0};
  logic [6:0] mmask [NI] = '{7'd0, 7'd0, 7'd0};
  int         merr  [NI] = '{0, 0, 0};

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        ph[i] = 0; kk[i] = 0; mv[i] = 2'd0; mbusy[i] = 1'b0; mdone[i] = 1'b0;
        mpass[i] = 1'b0; mmask[i] = 7'd0; merr[i] = 0;
      end else if (ph[i] == 0) begin
        mdone[i] = 1'b0;
        if (start_r && !abort_r) begin
          ph[i] = 1; kk[i] = 0; mv[i] = 2'd0; mbusy[i] = 1'b1;
          mmask[i] = 7'd0; mpass[i] = 1'b0; merr[i] = 0;
        end
      end else if (ph[i] == 1) begin
        int s1, len;
        logic [6:0] ex, d;
        s1  = SS[i] + 1;
        len = 4 * PP[i] * s1;
        if (kk[i] % s1 == s1 - 1) begin
          ex = ideal(mv[i][1], mv[i][0]);
          d  = ((ex & ~f0_r) | f1_r) ^ ex;
          mmask[i] = mmask[i] | d;
          merr[i]  = merr[i] + $countones(d);
          if (merr[i] > 255) merr[i] = 255;
        end
        if (abort_r) begin
          ph[i] = 0; mbusy[i] = 1'b0; mpass[i] = 1'b0;
        end else begin
          kk[i] = kk[i] + 1;
          if (kk[i] == len) begin
            ph[i] = 2; mbusy[i] = 1'b0; mdone[i] = 1'b1; mpass[i] = (mmask[i] == 7'd0);
          end else begin
            mv[i] = 2'((kk[i] / s1) % 4);
          end
        end
      end else begin
        ph[i] = 0; mdone[i] = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      logic [11:0] act, exq;
      act = {ta_w[i], tb_w[i], busy_w[i], done_w[i], pass_w[i], mask_w[i]};
      exq = {mv[i], mbusy[i], mdone[i], mpass[i], mmask[i]};
      checks++;
      if (act !== exq) begin
        failures++;
        $display("FAIL model_inst%0d t=%0t {a,b,busy,done,pass,mask} got 0x%03h expected 0x%03h",
                 i, $time, act, exq);
      end
`ifdef GATE_BIST_ERR_CNT_EN
      checks++;
      if (err_w[i] !== 8'(merr[i])) begin
        failures++;
        $display("FAIL model_err_inst%0d t=%0t got %0d expected %0d", i, $time, err_w[i], merr[i]);
      end
`endif
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exq);
    checks++;
    if (act !== exq) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exq);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int          de   [NI];
  logic [6:0]  dm   [NI];
  logic        dp   [NI];
`ifdef GATE_BIST_ERR_CNT_EN
  logic [7:0]  derr [NI];
`endif
  logic [15:0] seq0;
  logic [31:0] seq2;

  // Pulse start into edge 0 and record, per instance, the edge after which done was seen.
  task automatic watch(input int nedges);
    for (int i = 0; i < NI; i++) begin
      de[i] = -1; dm[i] = 7'd0; dp[i] = 1'b0;
    end
    seq0 = 16'd0;
    seq2 = 32'd0;
    start_r = 1'b1;
    for (int n = 0; n < nedges; n++) begin
      step();
      if (n == 0) start_r = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (done_w[i] && de[i] < 0) begin
          de[i] = n; dm[i] = mask_w[i]; dp[i] = pass_w[i];
`ifdef GATE_BIST_ERR_CNT_EN
          derr[i] = err_w[i];
`endif
        end
      end
      if (n < 8)  seq0 = {seq0[13:0], ta_w[0], tb_w[0]};
      if (n < 16) seq2 = {seq2[29:0], ta_w[2], tb_w[2]};
    end
  endtask

  // ---------------- directed scenarios, then random traffic ----------------
  initial begin
    rst_n   = 1'b0;
    start_r = 1'b0;
    abort_r = 1'b0;
    f0_r    = 7'd0;
    f1_r    = 7'd0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {20'd0, ta_w[0], tb_w[0], busy_w[0], done_w[0], pass_w[0], mask_w[0]}, 32'd0);
    rst_n = 1'b1;
    step();

    // good bank
    watch(24);
    chk("t1_done_edge", de[0], 8);
    chk("t1_pass", dp[0], 1);
    chk("t1_mask", dm[0], 0);
    chk("t1_vec_seq", seq0, 16'h05AF);
    chk("t1_p2_done_edge", de[1], 16);
    chk("t1_s3_done_edge", de[2], 16);

    // and stuck-at-0
    f0_r = 7'h01;
    watch(24);
    chk("t2_p1_mask", dm[0], 7'h01);
    chk("t2_done_edge", de[1], 16);
    chk("t2_mask", dm[1], 7'h01);
    chk("t2_pass", dp[1], 0);
`ifdef GATE_BIST_ERR_CNT_EN
    chk("t2_err_cnt", derr[1], 2);
`endif

    // xor stuck-at-1
    f0_r = 7'h00;
    f1_r = 7'h20;
    watch(24);
    chk("t3_done_edge", de[2], 16);
    chk("t3_mask", dm[2], 7'h20);
    chk("t3_vec_seq", seq2, 32'h0055AAFF);

    // abort during the second sample: and/or/not_a stuck-at-0
    f0_r = 7'h07;
    f1_r = 7'h00;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    repeat (3) step();
    abort_r = 1'b1;
    step();
    abort_r = 1'b0;
    chk("t4_busy", busy_w[0], 0);
    chk("t4_done", done_w[0], 0);
    chk("t4_pass", pass_w[0], 0);
    chk("t4_mask", mask_w[0], 7'h06);
    for (int n = 0; n < 10; n++) begin
      step();
      chk("t4_no_done", {busy_w[0], done_w[0]}, 2'b00);
    end

    // start while busy is ignored; start+abort in IDLE is refused
    f0_r = 7'h00;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    repeat (2) step();
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    repeat (5) step();
    chk("t5_done_edge8", done_w[0], 1);
    chk("t5_pass", pass_w[0], 1);
    step();
    start_r = 1'b1;
    abort_r = 1'b1;
    step();
    start_r = 1'b0;
    abort_r = 1'b0;
    chk("t5_start_abort_idle", busy_w[0], 0);
    repeat (3) step();
    chk("t5_stays_idle", busy_w[0], 0);
    repeat (12) step();

    // asynchronous reset in the middle of APPLY
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("t6_async_clear_inst%0d", i),
          {20'd0, ta_w[i], tb_w[i], busy_w[i], done_w[i], pass_w[i], mask_w[i]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    watch(24);
    chk("t6_rerun_done_edge", de[0], 8);
    chk("t6_rerun_pass", dp[0], 1);
    chk("t6_rerun_mask", dm[0], 0);

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (c % 60 == 0) begin
        f0_r = 7'($urandom) & 7'($urandom);
        f1_r = 7'($urandom) & 7'($urandom) & ~f0_r;
        if ($urandom_range(0, 2) == 0) begin
          f0_r = 7'd0;
          f1_r = 7'd0;
        end
      end
      start_r = ($urandom_range(0, 9) < 3);
      abort_r = ($urandom_range(0, 49) == 0);
      if (c == 700) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end
    start_r = 1'b0;
    abort_r = 1'b0;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
